// File: rtl/apb_slv_pkg.sv
// ============================================================================
// Module  : apb_slv_pkg
// Brief   : Shared types and defaults for the APB completer memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_slv_pkg;

    localparam int c_addr_width_dflt = 8;
    localparam int c_data_width_dflt = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef logic [1:0] wcnt_t;

endpackage

`default_nettype wire

// File: rtl/apb_slv_regfile.sv
// ============================================================================
// Module  : apb_slv_regfile
// Brief   : 2^ADDR_WIDTH x DATA_WIDTH array, async read, sync write and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width_dflt,
    parameter int DATA_WIDTH = c_data_width_dflt
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module  : apb_slave_mem
// Brief   : APB completer with register memory, optional wait states and a
//           sticky protocol-violation flag. Wait states: APB_SLV_WAIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_addr_width_dflt,
    parameter int DATA_WIDTH  = c_data_width_dflt,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PWAKEUP,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  prot_err,
    input  logic                  err_clr
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_prot_err;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_abort;
    logic                  w_latch;
    logic                  w_mem_we;
    logic                  w_err_set;
    logic                  w_wcnt_zero;

    // Any change of the transfer attributes during access aborts the transfer.
    assign w_abort = !PSEL || !PENABLE || (PADDR != r_addr) ||
                     (PWRITE != r_write) || (PWDATA != r_wdata);

`ifdef APB_SLV_WAIT_EN
    localparam wcnt_t c_wait_load = wcnt_t'(WAIT_CYCLES);

    wcnt_t r_wcnt;

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_wcnt <= '0;
        end else if (w_latch) begin
            r_wcnt <= c_wait_load;
        end else if ((r_state == ACCESS) && !w_abort && (r_wcnt != '0)) begin
            r_wcnt <= r_wcnt - wcnt_t'(1);
        end
    end

    assign w_wcnt_zero = (r_wcnt == '0);
`else
    assign w_wcnt_zero = 1'b1;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_mem_we    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (PENABLE) begin
                    w_err_set = 1'b1;
                end else if (PSEL) begin
                    if (PWAKEUP) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ACCESS;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (w_abort) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wcnt_zero) begin
                    w_mem_we    = r_write;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_prdata   <= '0;
            r_prot_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
            end
            // Read data is captured at setup and held until the next read setup.
            if (w_latch && !PWRITE) begin
                r_prdata <= w_rdata;
            end
            if (w_err_set) begin
                r_prot_err <= 1'b1;
            end else if (err_clr) begin
                r_prot_err <= 1'b0;
            end
        end
    end

    apb_slv_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRESET_N),
        .i_we    (w_mem_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (PADDR),
        .o_rdata (w_rdata)
    );

    assign PREADY   = (r_state == ACCESS) && w_wcnt_zero;
    assign PRDATA   = r_prdata;
    assign prot_err = r_prot_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// Module  : tb_apb_slave_mem
// Brief   : Self-checking bench for apb_slave_mem against a memory/flag model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int WAITS = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = WAITS;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET_N = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE = 1'b0;
    logic [DW-1:0] PWDATA = '0;
    logic          PWAKEUP = 1'b1;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          prot_err;
    logic          err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [2**AW];
    logic          m_err;
    logic [DW-1:0] m_prdata;

    apb_slave_mem #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .PCLK     (PCLK),
        .PRESET_N (PRESET_N),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PWAKEUP  (PWAKEUP),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .prot_err (prot_err),
        .err_clr  (err_clr)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWAKEUP = 1'b1;
        err_clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        m_err    = 1'b0;
        m_prdata = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pready"}, PREADY, 1'b0);
        chk({tag, "_prot_err"}, prot_err, m_err);
        chk({tag, "_prdata"}, PRDATA, m_prdata);
    endtask

    task automatic setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        PWAKEUP = 1'b1;
        err_clr = 1'b0;
        step();
        if (!wr) m_prdata = m_mem[a];
        PENABLE = 1'b1;
    endtask

    task automatic transfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        setup(wr, a, d);
        for (int k = 0; k <= EXP_WAITS; k++) begin
            chk(wr ? "wr_pready" : "rd_pready", PREADY, (k == EXP_WAITS));
            if (!wr && k == EXP_WAITS) chk("rd_prdata", PRDATA, m_prdata);
            step();
        end
        if (wr) m_mem[a] = d;
        bus_idle();
        check_idle(wr ? "wr_done" : "rd_done");
    endtask

    // kind: 0 drop PSEL, 1 drop PENABLE, 2 alter PADDR, 3 flip PWRITE, 4 alter PWDATA
    task automatic abort_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int kind, input int at_cycle, input logic [7:0] mask);
        setup(wr, a, d);
        for (int k = 0; k < at_cycle; k++) begin
            chk("abort_wait_pready", PREADY, 1'b0);
            step();
        end
        case (kind)
            0:       PSEL    = 1'b0;
            1:       PENABLE = 1'b0;
            2:       PADDR   = a ^ AW'(mask);
            3:       PWRITE  = ~wr;
            default: PWDATA  = d ^ DW'(mask);
        endcase
        step();
        m_err = 1'b1;
        bus_idle();
        check_idle("abort");
    endtask

    task automatic clear_err();
        bus_idle();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err   = 1'b0;
        chk("err_clr", prot_err, 1'b0);
    endtask

    task automatic wake_viol(input logic [AW-1:0] a, input logic [DW-1:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = a;
        PWDATA  = d;
        PWAKEUP = 1'b0;
        step();
        m_err = 1'b1;
        bus_idle();
        check_idle("wake_viol");
        step();
        chk("wake_viol_no_access", PREADY, 1'b0);
    endtask

    task automatic enable_viol(input logic sel, input logic clr);
        PSEL    = sel;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        err_clr = clr;
        step();
        m_err = 1'b1;
        bus_idle();
        check_idle("enable_viol");
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            op;

        // Reset held for two edges
        model_reset();
        bus_idle();
        PRESET_N = 1'b0;
        step();
        step();
        PRESET_N = 1'b1;
        check_idle("reset");
        transfer(1'b0, 8'h00, 8'h00);

        // Zero-wait or waited write/read pair, then back-to-back traffic
        transfer(1'b1, 8'h3C, 8'hA5);
        transfer(1'b0, 8'h3C, 8'h00);
        transfer(1'b1, 8'hFF, 8'h5A);
        transfer(1'b0, 8'hFF, 8'h00);
        transfer(1'b1, 8'h00, 8'hC3);
        transfer(1'b0, 8'h00, 8'h00);

        // Address change during access aborts; memory untouched
        abort_xfer(1'b1, 8'h10, 8'h11, 2, EXP_WAITS, 8'h01);
        transfer(1'b0, 8'h10, 8'h00);
        clear_err();

        // Setup without wakeup, enable without setup, clear losing to violation
        wake_viol(8'h40, 8'h99);
        transfer(1'b0, 8'h40, 8'h00);
        clear_err();
        enable_viol(1'b0, 1'b0);
        clear_err();
        enable_viol(1'b1, 1'b1);
        clear_err();

        // Reset during the access phase of a write
        setup(1'b1, 8'h20, 8'h77);
        PRESET_N = 1'b0;
        step();
        PRESET_N = 1'b1;
        bus_idle();
        model_reset();
        check_idle("mid_reset");
        transfer(1'b0, 8'h20, 8'h00);
        transfer(1'b0, 8'h3C, 8'h00);

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
            d  = DW'($urandom_range(0, 255));
            case (op)
                0, 1, 2, 3: transfer(1'b1, a, d);
                4, 5, 6:    transfer(1'b0, a, d);
                7:          abort_xfer(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 4)),
                                       int'($urandom_range(0, EXP_WAITS)), 8'($urandom_range(1, 255)));
                8:          enable_viol(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default:    clear_err();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
